// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR moving-average run controller: sequencer
// state encoding, display page codes, sample counter width and the page
// rotation helper.
// ----------------------------------------------------------------------------
package fir_pkg;

    localparam int SAMPLE_CNT_W = 36;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_STEP = 3'd2,
        S_AVG  = 3'd3,
        S_CONV = 3'd4
    } fir_state_e;

    localparam logic [1:0] PAGE_BLANK = 2'd0;
    localparam logic [1:0] PAGE_HI    = 2'd1;
    localparam logic [1:0] PAGE_MID   = 2'd2;
    localparam logic [1:0] PAGE_LO    = 2'd3;

    // Display rotation order: blank, high digits, middle digits, low digits.
    function automatic logic [1:0] next_page(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            PAGE_BLANK: nxt = PAGE_HI;
            PAGE_HI:    nxt = PAGE_MID;
            PAGE_MID:   nxt = PAGE_LO;
            PAGE_LO:    nxt = PAGE_BLANK;
            default:    nxt = PAGE_BLANK;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fir_run_controller_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Synchronises the raw active-low push button, filters it with a stability
// counter and emits a one-cycle press pulse on each accepted high->low edge.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_btn_n  - raw button, low = pressed, asynchronous to i_clk
//   o_press  - registered one-cycle pulse per accepted press
// ----------------------------------------------------------------------------
module btn_debounce
    import fir_pkg::*;
#(
    parameter int DEBOUNCE = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Two-flop synchroniser, stability counter and press edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                // Any sample equal to the accepted level restarts the run.
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                // This is the DEBOUNCE-th consecutive differing sample.
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= r_level & ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/fir_run_controller.sv
// ----------------------------------------------------------------------------
// fir_run_controller
// Run/stop sequencer for the FIR moving-average demo. A debounced button
// toggles the run; while running, a divided tick launches one sample through
// LFSR -> moving average -> BCD conversion with a start/done handshake on the
// converter. Completed samples are counted and the display page rotates
// freely.
//
// Ports:
//   CLOCK_50      - sole clock, rising edge
//   reset_n       - asynchronous active-low reset
//   toggle_btn_n  - raw run/stop button, low = pressed
//   conv_done     - one-cycle pulse from the BCD converter
//   running       - datapath enable
//   dp_clr        - one-cycle datapath clear on start
//   lfsr_step     - one-cycle LFSR advance
//   avg_step      - one-cycle moving-average update
//   conv_start    - one-cycle BCD conversion start
//   busy          - sample in flight (lfsr_step until conv_done accepted)
//   sample_count  - completed samples since last start
//   page          - display page (blank / hi / mid / lo digits)
//   overrun       - sticky: a tick was dropped because a sample was busy
// ----------------------------------------------------------------------------
module fir_run_controller
    import fir_pkg::*;
#(
    parameter int SAMPLE_DIV = 5_000_000,
    parameter int PAGE_DIV   = 50_000_000,
    parameter int DEBOUNCE   = 500_000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    toggle_btn_n,
    input  logic                    conv_done,
    output logic                    running,
    output logic                    dp_clr,
    output logic                    lfsr_step,
    output logic                    avg_step,
    output logic                    conv_start,
    output logic                    busy,
    output logic [SAMPLE_CNT_W-1:0] sample_count,
    output logic [1:0]              page,
    output logic                    overrun
);

    localparam int SDW = $clog2(SAMPLE_DIV);
    localparam int PDW = $clog2(PAGE_DIV);

    fir_state_e              r_state;
    logic                    r_running;
    logic                    r_stop_pend;
    logic                    r_busy;
    logic                    r_dp_clr;
    logic                    r_lfsr_step;
    logic                    r_avg_step;
    logic                    r_conv_start;
    logic [SAMPLE_CNT_W-1:0] r_sample_count;
    logic                    r_overrun;
    logic [SDW-1:0]          r_sample_div;
    logic [PDW-1:0]          r_page_div;
    logic [1:0]              r_page;

    logic w_press;
    logic w_start;
    logic w_tick;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_btn_n (toggle_btn_n),
        .o_press (w_press)
    );

    assign w_start = w_press & (r_state == S_IDLE);
    assign w_tick  = r_running & (r_sample_div == SDW'(SAMPLE_DIV - 1));

    // Sample pacing divider: counts only while running, restarts on start.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_div <= '0;
        end else if (!r_running || w_start || w_tick) begin
            r_sample_div <= '0;
        end else begin
            r_sample_div <= r_sample_div + SDW'(1);
        end
    end

    // Free-running page rotation; realigned to blank on every start.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_page_div <= '0;
            r_page     <= PAGE_BLANK;
        end else if (w_start) begin
            r_page_div <= '0;
            r_page     <= PAGE_BLANK;
        end else if (r_page_div == PDW'(PAGE_DIV - 1)) begin
            r_page_div <= '0;
            r_page     <= next_page(r_page);
        end else begin
            r_page_div <= r_page_div + PDW'(1);
        end
    end

    // Run/stop sequencer with registered step pulses, counter and overrun flag.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_running      <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_busy         <= 1'b0;
            r_dp_clr       <= 1'b0;
            r_lfsr_step    <= 1'b0;
            r_avg_step     <= 1'b0;
            r_conv_start   <= 1'b0;
            r_sample_count <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_dp_clr     <= 1'b0;
            r_lfsr_step  <= 1'b0;
            r_avg_step   <= 1'b0;
            r_conv_start <= 1'b0;
            // A tick can only be taken in S_WAIT, where busy is already low.
            if (w_tick && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_state        <= S_WAIT;
                        r_running      <= 1'b1;
                        r_dp_clr       <= 1'b1;
                        r_sample_count <= '0;
                        r_overrun      <= 1'b0;
                        r_stop_pend    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A stop press beats a simultaneous tick.
                    if (w_press) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end else if (w_tick) begin
                        r_state     <= S_STEP;
                        r_lfsr_step <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_state    <= S_AVG;
                    r_avg_step <= 1'b1;
                    if (w_press) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                S_AVG: begin
                    r_state      <= S_CONV;
                    r_conv_start <= 1'b1;
                    if (w_press) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (conv_done) begin
                        r_sample_count <= r_sample_count + SAMPLE_CNT_W'(1);
                        r_busy         <= 1'b0;
                        // A press landing with conv_done is still a stop.
                        if (r_stop_pend || w_press) begin
                            r_state     <= S_IDLE;
                            r_running   <= 1'b0;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_press) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_running   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_stop_pend <= 1'b0;
                end
            endcase
        end
    end

    assign running      = r_running;
    assign dp_clr       = r_dp_clr;
    assign lfsr_step    = r_lfsr_step;
    assign avg_step     = r_avg_step;
    assign conv_start   = r_conv_start;
    assign busy         = r_busy;
    assign sample_count = r_sample_count;
    assign page         = r_page;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fir_run_controller.sv
`timescale 1ns/1ps
module tb_fir_run_controller;
    import fir_pkg::*;

    localparam int SAMPLE_DIV = 8;
    localparam int PAGE_DIV   = 16;
    localparam int DEBOUNCE   = 4;

    localparam int SEL_RUN  = 0;
    localparam int SEL_BUSY = 1;
    localparam int SEL_LFSR = 2;
    localparam int SEL_AVG  = 3;
    localparam int SEL_CS   = 4;

    logic        CLOCK_50     = 1'b0;
    logic        reset_n      = 1'b0;
    logic        toggle_btn_n = 1'b1;
    logic        conv_done    = 1'b0;
    logic        running;
    logic        dp_clr;
    logic        lfsr_step;
    logic        avg_step;
    logic        conv_start;
    logic        busy;
    logic [35:0] sample_count;
    logic [1:0]  page;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // converter model / scoreboard state
    logic [35:0] exp_count = 36'd0;
    logic [35:0] sb_q[$];
    int conv_dly    = 4;
    int conv_timer  = 0;
    int exp_period  = 0;
    int n_lfsr      = 0;
    int n_conv      = 0;
    int n_dpclr     = 0;
    int n_done      = 0;
    int last_lfsr   = -1;
    int run_rise_cyc = 0;
    int press_cyc   = 0;
    logic prev_busy = 1'b0;
    logic prev_run  = 1'b0;

    fir_run_controller #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .PAGE_DIV   (PAGE_DIV),
        .DEBOUNCE   (DEBOUNCE)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .toggle_btn_n (toggle_btn_n),
        .conv_done    (conv_done),
        .running      (running),
        .dp_clr       (dp_clr),
        .lfsr_step    (lfsr_step),
        .avg_step     (avg_step),
        .conv_start   (conv_start),
        .busy         (busy),
        .sample_count (sample_count),
        .page         (page),
        .overrun      (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic sig_sel(input int which);
        logic v;
        case (which)
            SEL_RUN:  v = running;
            SEL_BUSY: v = busy;
            SEL_LFSR: v = lfsr_step;
            SEL_AVG:  v = avg_step;
            SEL_CS:   v = conv_start;
            default:  v = 1'b0;
        endcase
        return v;
    endfunction

    task automatic wait_for(input string tag, input int which, input logic val, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK_50);
            if (sig_sel(which) == val) begin
                ok = 1'b1;
                break;
            end
        end
        check_val({"wait_", tag}, 64'(ok), 64'd1);
    endtask

    task automatic wait_samples(input string tag, input int target, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK_50);
            if (n_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check_val({"samples_", tag}, 64'(ok), 64'd1);
    endtask

    task automatic press(input int hold);
        @(negedge CLOCK_50);
        toggle_btn_n = 1'b0;
        press_cyc = cyc;
        repeat (hold) @(negedge CLOCK_50);
        toggle_btn_n = 1'b1;
    endtask

    // Converter model, pulse-order checks and completion scoreboard.
    always @(negedge CLOCK_50) begin
        if (!reset_n) begin
            conv_done  = 1'b0;
            conv_timer = 0;
            prev_busy  = 1'b0;
            prev_run   = 1'b0;
            last_lfsr  = -1;
            exp_count  = 36'd0;
            sb_q.delete();
        end else begin
            conv_done = 1'b0;
            if (conv_start) begin
                n_conv++;
                conv_timer = conv_dly;
            end else if (conv_timer > 0) begin
                conv_timer--;
                if (conv_timer == 0) begin
                    conv_done = 1'b1;
                    exp_count = exp_count + 36'd1;
                    sb_q.push_back(exp_count);
                end
            end
            if (dp_clr) begin
                n_dpclr++;
                exp_count = 36'd0;
                last_lfsr = -1;
            end
            if (dp_clr | lfsr_step | avg_step | conv_start)
                check_val("pulse_excl", 64'($countones({dp_clr, lfsr_step, avg_step, conv_start})), 64'd1);
            if (lfsr_step) begin
                if (last_lfsr >= 0 && exp_period > 0)
                    check_val("lfsr_period", 64'(cyc - last_lfsr), 64'(exp_period));
                check_val("busy_at_lfsr", 64'(busy), 64'd1);
                last_lfsr = cyc;
                n_lfsr++;
            end
            if (avg_step)   check_val("avg_after_lfsr", 64'(cyc - last_lfsr), 64'd1);
            if (conv_start) check_val("cs_after_lfsr", 64'(cyc - last_lfsr), 64'd2);
            if (prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_nonempty", 64'd0, 64'd1);
                end else begin
                    n_done++;
                    check_val("sample_count", 64'(sample_count), 64'(sb_q.pop_front()));
                end
            end
            if (running && !prev_run) run_rise_cyc = cyc;
            prev_busy = busy;
            prev_run  = running;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_lfsr;
        int base_done;
        int base_conv;

        // ---------------- reset state ----------------
        repeat (3) @(negedge CLOCK_50);
        check_val("rst_running", 64'(running), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_pulses", 64'({dp_clr, lfsr_step, avg_step, conv_start}), 64'd0);
        check_val("rst_count", 64'(sample_count), 64'd0);
        check_val("rst_page", 64'(page), 64'd0);
        check_val("rst_overrun", 64'(overrun), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // ---------------- glitch and chatter: no start ----------------
        press(3);
        repeat (10) @(negedge CLOCK_50);
        for (int i = 0; i < 6; i++) begin
            press(2);
            repeat (2) @(negedge CLOCK_50);
        end
        repeat (12) @(negedge CLOCK_50);
        check_val("glitch_no_run", 64'(running), 64'd0);
        check_val("glitch_no_dpclr", 64'(n_dpclr), 64'd0);

        // ---------------- clean start, steady sampling ----------------
        exp_period = SAMPLE_DIV;
        press(10);
        repeat (10) @(negedge CLOCK_50);
        check_val("start_latency", 64'(run_rise_cyc - press_cyc), 64'(2 + DEBOUNCE + 1));
        check_val("running_on", 64'(running), 64'd1);
        wait_samples("steady", 4, 200);
        check_val("dpclr_once", 64'(n_dpclr), 64'd1);
        check_val("no_overrun", 64'(overrun), 64'd0);

        // ---------------- stop press lands on the S_WAIT tick ----------------
        wait_for("lfsr_s3", SEL_LFSR, 1'b1, 40);
        @(negedge CLOCK_50);
        toggle_btn_n = 1'b0;
        base_lfsr = n_lfsr;
        repeat (10) @(negedge CLOCK_50);
        toggle_btn_n = 1'b1;
        check_val("stop_wait_run", 64'(running), 64'd0);
        repeat (30) @(negedge CLOCK_50);
        check_val("stop_wait_nolfsr", 64'(n_lfsr), 64'(base_lfsr));
        check_val("stop_wait_busy", 64'(busy), 64'd0);

        // ---------------- slow converter: overrun ----------------
        conv_dly   = 12;
        exp_period = 2 * SAMPLE_DIV;
        base_done  = n_done;
        press(10);
        check_val("restart_count", 64'(sample_count), 64'd0);
        check_val("restart_ovr0", 64'(overrun), 64'd0);
        wait_samples("overrun", base_done + 3, 300);
        check_val("overrun_set", 64'(overrun), 64'd1);

        // ---------------- stop during S_CONV ----------------
        wait_for("lfsr_s5", SEL_LFSR, 1'b1, 60);
        conv_dly   = 20;
        exp_period = 0;
        wait_for("cs_s5", SEL_CS, 1'b1, 10);
        @(negedge CLOCK_50);
        toggle_btn_n = 1'b0;
        base_lfsr = n_lfsr;
        base_done = n_done;
        repeat (7) @(negedge CLOCK_50);
        check_val("conv_stop_run_hold", 64'(running), 64'd1);
        check_val("conv_stop_busy_hold", 64'(busy), 64'd1);
        toggle_btn_n = 1'b1;
        wait_for("busy_fall_s5", SEL_BUSY, 1'b0, 40);
        check_val("conv_stop_run_off", 64'(running), 64'd0);
        repeat (30) @(negedge CLOCK_50);
        check_val("conv_stop_nolfsr", 64'(n_lfsr), 64'(base_lfsr));
        check_val("conv_stop_done", 64'(n_done), 64'(base_done + 1));

        // ---------------- restart clears overrun, page rotation ----------------
        conv_dly   = 4;
        exp_period = SAMPLE_DIV;
        press(10);
        check_val("restart2_count", 64'(sample_count), 64'd0);
        check_val("restart2_ovr", 64'(overrun), 64'd0);
        for (int i = 0; i < 5; i++) begin
            while (cyc < run_rise_cyc + PAGE_DIV * i + PAGE_DIV / 2) @(negedge CLOCK_50);
            check_val("page", 64'(page), 64'(i % 4));
        end

        // ---------------- 36-bit wrap ----------------
        wait_for("lfsr_wrap", SEL_LFSR, 1'b1, 40);
        force dut.r_sample_count = 36'hF_FFFF_FFFF;
        exp_count = 36'hF_FFFF_FFFF;
        base_done = n_done;
        @(negedge CLOCK_50);
        release dut.r_sample_count;
        wait_samples("wrap", base_done + 1, 40);
        check_val("wrap_zero", 64'(sample_count), 64'd0);

        // stop, then restart clears the count
        press(6);
        wait_for("stop_s6", SEL_RUN, 1'b0, 60);
        repeat (12) @(negedge CLOCK_50);
        press(10);
        check_val("restart3_count", 64'(sample_count), 64'd0);
        check_val("restart3_ovr", 64'(overrun), 64'd0);
        wait_samples("after_restart3", n_done + 2, 100);

        // ---------------- reset during S_AVG ----------------
        wait_for("avg_s7", SEL_AVG, 1'b1, 60);
        base_conv = n_conv;
        #1 reset_n = 1'b0;
        #1;
        check_val("abort_running", 64'(running), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_pulses", 64'({dp_clr, lfsr_step, avg_step, conv_start}), 64'd0);
        check_val("abort_count", 64'(sample_count), 64'd0);
        check_val("abort_page", 64'(page), 64'd0);
        check_val("abort_overrun", 64'(overrun), 64'd0);
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        check_val("abort_no_cs", 64'(n_conv), 64'(base_conv));
        check_val("abort_idle", 64'(running), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_run_controller.md
# fir_run_controller

Run/stop sequencer for the FIR moving-average demo. It debounces the start/stop button and paces sample generation from a divided tick. For each sample it steps the LFSR source, then the moving-average stage, then the binary-to-BCD converter, with a start/done handshake on the converter. It also counts processed samples and rotates the three-digit display through its result pages. It sits between the board inputs (CLOCK_50, push button) and the LFSR / moving-average / BCD / 7-segment datapath, and replaces the ad-hoc enable toggling and initialisation of that datapath.

## Interface
- SAMPLE_DIV, 5_000_000: CLOCK_50 cycles per sample tick (10 Hz); minimum 8.
- PAGE_DIV, 50_000_000: CLOCK_50 cycles per display page advance; minimum 2.
- DEBOUNCE, 500_000: cycles the synchronised button must be stable before it is accepted; minimum 2.
- CLOCK_50  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- toggle_btn_n  in  1  raw push button, low = pressed, asynchronous to the clock.
- conv_done  in  1  one-cycle pulse from the BCD converter when its digits are valid.
- running  out  1  high while the run is enabled; this is the datapath enable.
- dp_clr  out  1  one-cycle pulse on start; clears the LFSR seed, average taps and converter.
- lfsr_step  out  1  one-cycle pulse: LFSR advances one sample.
- avg_step  out  1  one-cycle pulse: moving average accepts the new sample.
- conv_start  out  1  one-cycle pulse: BCD conversion of the new average begins.
- busy  out  1  high from lfsr_step until conv_done is accepted.
- sample_count  out  36  number of completed samples since the last start.
- page  out  2  display page: 0 blank, 1 digits 8..6, 2 digits 5..3, 3 digits 2..0.
- overrun  out  1  sticky; a sample tick was dropped because the previous sample was still busy.

## Operation
- Button path:
  - 2-FF synchroniser, then a stability counter; the debounced level updates after DEBOUNCE consecutive equal samples.
  - A debounced high→low transition is one press. Holding the button produces exactly one press.
- Press while stopped (start):
  - running←1 and dp_clr pulses.
  - sample_count←0, overrun←0, sample divider←0, page←0.
- Press while running (stop request):
  - If the FSM is in S_WAIT, go to S_IDLE next cycle with running←0.
  - Otherwise latch stop_pend. The current sample completes through conv_done, then the FSM goes to S_IDLE with running←0.
- FSM states:
  - S_IDLE: running=0; go to S_WAIT on start.
  - S_WAIT: on sample tick go to S_STEP.
  - S_STEP: lfsr_step=1; go to S_AVG.
  - S_AVG: avg_step=1; go to S_CONV.
  - S_CONV: conv_start=1 on entry cycle only; hold until conv_done.
  - On conv_done: sample_count+1 (wraps at 2^36−1→0), then go to S_WAIT, or S_IDLE if stop_pend.
- Sample tick: divider counts 0..SAMPLE_DIV−1 while running; tick when it equals SAMPLE_DIV−1. A tick occurring while busy=1 is dropped and sets overrun.
- Page rotation: free-running 0→1→2→3→0 every PAGE_DIV cycles, running or not, so results stay readable after stop.
- conv_done outside S_CONV is ignored.
- A start press received while stop_pend is set is ignored.

## Timing
- Reset values (asynchronous, reset_n low):
  - All outputs 0; FSM in S_IDLE; all counters 0; debounced level 1 (released).
- Press to running: 2 synchroniser cycles + DEBOUNCE cycles + 1 cycle.
- Pulse sequence after tick:
  - lfsr_step at cycle t+1.
  - avg_step at t+2.
  - conv_start at t+3; busy rises at t+1.
  - busy falls and sample_count increments in the cycle after conv_done.
- Each of lfsr_step, avg_step, conv_start and dp_clr is exactly one cycle wide; they are mutually exclusive.
- reset_n asserted mid-sample aborts immediately; no completion pulse follows.
- A tick and a stop press in the same cycle in S_WAIT: stop wins, no lfsr_step.

## Structure
- Shared package fir_pkg holds:
  - the state encoding (S_IDLE..S_CONV);
  - the page constants (PAGE_BLANK, PAGE_HI, PAGE_MID, PAGE_LO);
  - SAMPLE_CNT_W=36.
- One sub-module: btn_debounce (synchroniser, stability counter, press pulse), parameterised by DEBOUNCE.
- Dividers and the FSM stay in fir_run_controller.

## Test plan
Bench parameters: SAMPLE_DIV=8, PAGE_DIV=16, DEBOUNCE=4.
- Reset, then one 10-cycle press, converter answering conv_done 5 cycles after conv_start → dp_clr once; sequence lfsr_step/avg_step/conv_start repeats every 8 cycles; sample_count 1,2,3…
- 3-cycle button glitch and chattering bouncing every 2 cycles → no start; then a clean 10-cycle hold → exactly one start.
- Converter delays conv_done 12 cycles → overrun=1, one tick dropped, sample_count still increments once per conv_done.
- Stop press during S_CONV → running stays 1 until conv_done; count increments; then running=0 with no further lfsr_step.
- Force sample_count to 2^36−1 (force/preload) and complete one sample → sample_count=0; restart after stop → sample_count=0, overrun=0.
- Observe page over 64 cycles → 0,1,2,3 every 16 cycles. Assert reset_n mid-S_AVG → all outputs 0 in the same cycle.
